mem_port_arbiter: RTL and testbench

- Shares the single external matrix memory port between two requesters: requester 0 is the operand loader (reads of memory 1 and memory 2); requester 1 is the result writer (writes of final-matrix words).
- Provides round-robin, burst-oriented grants with a bounded burst length.
- Sits between the matrix-multiply controller/datapath and the memory.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: the two requester handshakes plus the shared memory port driven by mem_port_arbiter.
// master = requester/memory side, slave = the arbiter itself.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              req0;
   logic              valid0;
   logic [ADDR_W-1:0] addr0;
   logic              we0;
   logic [DATA_W-1:0] wdata0;

   logic              req1;
   logic              valid1;
   logic [ADDR_W-1:0] addr1;
   logic              we1;
   logic [DATA_W-1:0] wdata1;

   logic              gnt0;
   logic              gnt1;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              burst_end;

   modport master (
      output req0, valid0, addr0, we0, wdata0,
      output req1, valid1, addr1, we1, wdata1,
      input  gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata, burst_end
   );

   modport slave (
      input  req0, valid0, addr0, we0, wdata0,
      input  req1, valid1, addr1, we1, wdata1,
      output gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata, burst_end
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, burst-bounded sharing of one memory port between operand loader (0) and result writer (1).
// Define ARB_STATS_EN to add saturating per-requester beat counters and an IDLE conflict counter.
module mem_port_arbiter #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 9
) (
   input  logic clk,
   input  logic rst,
   mem_port_arbiter_if.slave arbIf
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] stat_beats0,
   output logic [15:0] stat_beats1,
   output logic [15:0] stat_conflicts
`endif
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

   state_t            state_q;
   logic              lastServed_q;
   logic [3:0]        beatCnt_q;
   logic              gnt0_q;
   logic              gnt1_q;

   logic              accept0;
   logic              accept1;
   logic              accept;
   logic [3:0]        beatCntInc;
   logic              burstEnd;
   logic [ADDR_W-1:0] muxAddr;
   logic [DATA_W-1:0] muxWdata;

   assign accept0    = gnt0_q & arbIf.req0 & arbIf.valid0;
   assign accept1    = gnt1_q & arbIf.req1 & arbIf.valid1;
   assign accept     = accept0 | accept1;
   assign beatCntInc = beatCnt_q + 4'd1;
   assign burstEnd   = accept & (beatCntInc == MaxBurst);

   // The granted requester's address/data reach memory even on idle beats; IDLE drives zeros.
   always_comb begin
      muxAddr  = '0;
      muxWdata = '0;
      if (gnt0_q) begin
         muxAddr  = arbIf.addr0;
         muxWdata = arbIf.wdata0;
      end else if (gnt1_q) begin
         muxAddr  = arbIf.addr1;
         muxWdata = arbIf.wdata1;
      end
   end

   assign arbIf.gnt0      = gnt0_q;
   assign arbIf.gnt1      = gnt1_q;
   assign arbIf.mem_en    = accept;
   assign arbIf.mem_we    = (accept0 & arbIf.we0) | (accept1 & arbIf.we1);
   assign arbIf.mem_addr  = muxAddr;
   assign arbIf.mem_wdata = muxWdata;
   assign arbIf.burst_end = burstEnd;

   // Every grant returns through IDLE, so the grants never overlap or switch back-to-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         lastServed_q <= 1'b1;
         beatCnt_q    <= 4'd0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arbIf.req0 && (!arbIf.req1 || lastServed_q)) begin
                  state_q <= GRANT0;
                  gnt0_q  <= 1'b1;
               end else if (arbIf.req1) begin
                  state_q <= GRANT1;
                  gnt1_q  <= 1'b1;
               end
            end
            GRANT0: begin
               if (!arbIf.req0 || burstEnd) begin
                  state_q      <= IDLE;
                  gnt0_q       <= 1'b0;
                  lastServed_q <= 1'b0;
                  beatCnt_q    <= 4'd0;
               end else if (accept0) begin
                  beatCnt_q <= beatCntInc;
               end
            end
            GRANT1: begin
               if (!arbIf.req1 || burstEnd) begin
                  state_q      <= IDLE;
                  gnt1_q       <= 1'b0;
                  lastServed_q <= 1'b1;
                  beatCnt_q    <= 4'd0;
               end else if (accept1) begin
                  beatCnt_q <= beatCntInc;
               end
            end
            default: begin
               state_q   <= IDLE;
               gnt0_q    <= 1'b0;
               gnt1_q    <= 1'b0;
               beatCnt_q <= 4'd0;
            end
         endcase
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] statBeats0_q;
   logic [15:0] statBeats1_q;
   logic [15:0] statConflicts_q;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         statBeats0_q    <= 16'd0;
         statBeats1_q    <= 16'd0;
         statConflicts_q <= 16'd0;
      end else begin
         if (accept0 && statBeats0_q != 16'hFFFF) begin
            statBeats0_q <= statBeats0_q + 16'd1;
         end
         if (accept1 && statBeats1_q != 16'hFFFF) begin
            statBeats1_q <= statBeats1_q + 16'd1;
         end
         if (state_q == IDLE && arbIf.req0 && arbIf.req1 && statConflicts_q != 16'hFFFF) begin
            statConflicts_q <= statConflicts_q + 16'd1;
         end
      end
   end

   assign stat_beats0    = statBeats0_q;
   assign stat_beats1    = statBeats1_q;
   assign stat_conflicts = statConflicts_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter.
module tb_mem_port_arbiter;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 9;

   logic clk;
   logic rst;
   int   vectorCount = 0;
   int   missCount   = 0;

   logic [DATA_W-1:0] writeData [3] = '{8'h11, 8'h22, 8'h33};
   int                validPat  [11] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
   logic [15:0] statBeats0;
   logic [15:0] statBeats1;
   logic [15:0] statConflicts;
`endif

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .rst   (rst),
      .arbIf (bus)
`ifdef ARB_STATS_EN
      ,
      .stat_beats0    (statBeats0),
      .stat_beats1    (statBeats1),
      .stat_conflicts (statConflicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkPort(input string tag, input logic g0, input logic g1, input logic en,
                            input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic be);
      checkOutput({tag, ".gnt0"},      32'(bus.gnt0),             32'(g0));
      checkOutput({tag, ".gnt1"},      32'(bus.gnt1),             32'(g1));
      checkOutput({tag, ".excl"},      32'(bus.gnt0 & bus.gnt1),  32'(0));
      checkOutput({tag, ".mem_en"},    32'(bus.mem_en),           32'(en));
      checkOutput({tag, ".mem_we"},    32'(bus.mem_we),           32'(we));
      checkOutput({tag, ".mem_addr"},  32'(bus.mem_addr),         32'(addr));
      checkOutput({tag, ".mem_wdata"}, 32'(bus.mem_wdata),        32'(wdata));
      checkOutput({tag, ".burst_end"}, 32'(bus.burst_end),        32'(be));
   endtask

   task automatic applyStimulus(input logic r0, input logic v0, input logic [ADDR_W-1:0] a0,
                                input logic w0, input logic [DATA_W-1:0] d0,
                                input logic r1, input logic v1, input logic [ADDR_W-1:0] a1,
                                input logic w1, input logic [DATA_W-1:0] d1);
      bus.req0   = r0;
      bus.valid0 = v0;
      bus.addr0  = a0;
      bus.we0    = w0;
      bus.wdata0 = d0;
      bus.req1   = r1;
      bus.valid1 = v1;
      bus.addr1  = a1;
      bus.we1    = w1;
      bus.wdata1 = d1;
   endtask

   task automatic toCheckPoint();
      @(negedge clk);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      toCheckPoint();
      checkPort("reset", 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      nextCycle();

      // Single requester, full 9-beat read burst.
      applyStimulus(1, 1, 0, 0, 8'h5A, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t1.idle", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1, 1, ADDR_W'(k), 0, 8'h5A, 0, 0, 0, 0, 0);
         toCheckPoint();
         checkPort($sformatf("t1.beat%0d", k), 1, 0, 1, 0, ADDR_W'(k), 8'h5A, k == 8);
         nextCycle();
      end
      applyStimulus(0, 1, 5'd7, 0, 8'h5A, 0, 1, 5'd9, 1, 8'h77);
      toCheckPoint();
      checkPort("t1.after", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();

      // Both requesters from reset: 0 wins first, then strict alternation with a dead cycle.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int g = 0; g < 4; g++) begin
         applyStimulus(1, 1, 0, 0, 8'h00, 1, 1, 5'd16, 1, 8'hA0);
         toCheckPoint();
         checkPort($sformatf("t2.g%0d.idle", g), 0, 0, 0, 0, 0, 0, 0);
         nextCycle();
         for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 1, ADDR_W'(k), 0, 8'h00, 1, 1, ADDR_W'(16 + k), 1, DATA_W'(8'hA0 + k));
            toCheckPoint();
            if (g % 2 == 0)
               checkPort($sformatf("t2.g%0d.b%0d", g, k), 1, 0, 1, 0, ADDR_W'(k), 8'h00, k == 8);
            else
               checkPort($sformatf("t2.g%0d.b%0d", g, k), 0, 1, 1, 1, ADDR_W'(16 + k),
                         DATA_W'(8'hA0 + k), k == 8);
            nextCycle();
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t2.end", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();

      // Short write burst from requester 1, ended by dropping req1.
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd18, 1, 8'h11);
      toCheckPoint();
      checkPort("t4.idle", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 1, ADDR_W'(18 + k), 1, writeData[k]);
         toCheckPoint();
         checkPort($sformatf("t4.beat%0d", k), 0, 1, 1, 1, ADDR_W'(18 + k), writeData[k], 0);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd20, 1, 8'h33);
      toCheckPoint();
      checkPort("t4.drop", 0, 1, 0, 0, 5'd20, 8'h33, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t4.after", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();

      // valid0 gaps: only valid cycles issue beats and advance the count.
      applyStimulus(1, 1, 5'd3, 0, 8'h00, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t5.idle", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1, validPat[i] != 0, ADDR_W'(i), 0, 8'h00, 0, 0, 0, 0, 0);
         toCheckPoint();
         checkPort($sformatf("t5.cyc%0d", i), 1, 0, validPat[i] != 0, 0, ADDR_W'(i), 8'h00, i == 10);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t5.after", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();

      // Asynchronous reset during beat 4, then a fresh full burst.
      applyStimulus(1, 1, 0, 1, 8'hC0, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t6.idle", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 1, ADDR_W'(k), 1, 8'hC0, 0, 0, 0, 0, 0);
         toCheckPoint();
         checkPort($sformatf("t6.pre%0d", k), 1, 0, 1, 1, ADDR_W'(k), 8'hC0, 0);
         nextCycle();
      end
      applyStimulus(1, 1, 5'd3, 1, 8'hC0, 0, 0, 0, 0, 0);
      #1;
      checkPort("t6.beat4", 1, 0, 1, 1, 5'd3, 8'hC0, 0);
      rst = 1'b1;
      #1;
      checkPort("t6.rst", 0, 0, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t6.rsthold", 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      nextCycle();
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1, 1, ADDR_W'(k), 1, DATA_W'(8'hC0 + k), 0, 0, 0, 0, 0);
         toCheckPoint();
         checkPort($sformatf("t6.beat%0d", k), 1, 0, 1, 1, ADDR_W'(k), DATA_W'(8'hC0 + k), k == 8);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      toCheckPoint();
      checkPort("t6.after", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end
endmodule
